// File: rtl/sm_arith_pkg.sv
// Shared types and helpers for 21-bit sign-magnitude arithmetic.
// Sign is bit 20 (1 = negative), magnitude is bits 19:0.
package sm_arith_pkg;

  localparam int unsigned SM_W     = 21;
  localparam int unsigned SM_MAG_W = 20;

  typedef struct packed {
    logic                sign;
    logic [SM_MAG_W-1:0] mag;
  } sm21_t;

  // Both +0 and -0 count as zero.
  function automatic logic sm_is_zero(input sm21_t v);
    return ~|v.mag;
  endfunction

endpackage

// File: rtl/sm_mag_addsub.sv
// Combinational magnitude adder/subtractor. When subtracting it always takes
// larger minus smaller, so the result is a non-negative magnitude.
module sm_mag_addsub
  import sm_arith_pkg::*;
#(
  parameter int unsigned MagW = SM_MAG_W
) (
  input  logic [MagW-1:0] mag_a,
  input  logic [MagW-1:0] mag_b,
  input  logic            op_sub,
  output logic [MagW-1:0] mag_res,
  output logic            carry,
  output logic            a_ge_b
);

  logic [MagW:0] add_full;

  assign add_full = {1'b0, mag_a} + {1'b0, mag_b};
  assign a_ge_b   = (mag_a >= mag_b);

  always_comb begin
    mag_res = '0;
    carry   = 1'b0;
    if (op_sub) begin
      mag_res = a_ge_b ? (mag_a - mag_b) : (mag_b - mag_a);
    end else begin
      mag_res = add_full[MagW-1:0];
      carry   = add_full[MagW];
    end
  end

endmodule

// File: rtl/sign_mag_adder_21.sv
// Registered sign-magnitude adder node for the neuron adder tree, one-cycle latency.
// Define SM_ADD_SATURATE_EN to saturate the magnitude on overflow instead of wrapping.
module sign_mag_adder_21
  import sm_arith_pkg::*;
#(
  parameter int unsigned WIDTH = SM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  sm21_t            a_s;
  sm21_t            b_s;
  logic             a_neg;
  logic             b_neg;
  logic             op_sub;
  logic [WIDTH-2:0] mag_res;
  logic             carry;
  logic             a_ge_b;

  logic [WIDTH-2:0] mag_d;
  logic             sign_d;
  logic             ovf_d;

  logic [WIDTH-1:0] sum_q;
  logic             ovf_q;
  logic             valid_q;

  assign a_s = a;
  assign b_s = b;

  // -0 is folded to +0 up front so it never steers the result sign.
  assign a_neg  = a_s.sign & ~sm_is_zero(a_s);
  assign b_neg  = b_s.sign & ~sm_is_zero(b_s);
  assign op_sub = a_neg ^ b_neg;

  sm_mag_addsub #(
    .MagW (WIDTH - 1)
  ) u_mag_addsub (
    .mag_a   (a_s.mag),
    .mag_b   (b_s.mag),
    .op_sub  (op_sub),
    .mag_res (mag_res),
    .carry   (carry),
    .a_ge_b  (a_ge_b)
  );

  always_comb begin
    ovf_d = carry;
`ifdef SM_ADD_SATURATE_EN
    mag_d = carry ? {(WIDTH - 1){1'b1}} : mag_res;
`else
    mag_d = mag_res;
`endif
    if (op_sub) begin
      sign_d = a_ge_b ? a_neg : b_neg;
    end else begin
      sign_d = a_neg;
    end
    // A zero result (cancellation or wrap) is always reported as +0.
    if (~|mag_d) begin
      sign_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q <= {sign_d, mag_d};
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sign_mag_adder_21.sv
// Scoreboard bench for sign_mag_adder_21: expected results are queued at drive
// time and popped when the DUT presents a valid result.
module tb_sign_mag_adder_21;

  localparam int unsigned W = 21;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         ovf;

  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];
  exp_t last_exp;
  logic fired;

  sign_mag_adder_21 #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .sum       (sum),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%06h, expected 0x%06h", tag, obs, exp);
    end
  endtask

  // Reference model in plain signed integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t r;
    int   vx;
    int   vy;
    int   tot;
    int   mag;
    vx  = x[W-1] ? -int'(x[W-2:0]) : int'(x[W-2:0]);
    vy  = y[W-1] ? -int'(y[W-2:0]) : int'(y[W-2:0]);
    tot = vx + vy;
    mag = (tot < 0) ? -tot : tot;
    r.ovf = (mag > 32'h000F_FFFF);
    if (r.ovf) begin
`ifdef SM_ADD_SATURATE_EN
      mag = 32'h000F_FFFF;
`else
      mag = mag & 32'h000F_FFFF;
`endif
    end
    r.sum = {(tot < 0) && (mag != 0), mag[W-2:0]};
    return r;
  endfunction

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk);
    #1;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    exp_q.push_back(model(x, y));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = $urandom();
      b        = $urandom();
    end
  endtask

  // in_valid is only changed 1 time unit after a rising edge, so this is race-free.
  always @(posedge clk) fired = in_valid & rst_n;

  always @(negedge clk) begin
    exp_t e;
    check_eq("out_valid", 32'(out_valid), 32'(fired));
    if (fired) begin
      if (exp_q.size() == 0) begin
        check_eq("queue_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("sum", 32'(sum), 32'(e.sum));
        check_eq("ovf", 32'(ovf), 32'(e.ovf));
        last_exp = e;
      end
    end else begin
      check_eq("sum_hold", 32'(sum), 32'(last_exp.sum));
      check_eq("ovf_hold", 32'(ovf), 32'(last_exp.ovf));
    end
  end

  initial begin
    logic [W-1:0] dir_a [12];
    logic [W-1:0] dir_b [12];
    n_tests  = 0;
    n_fail   = 0;
    last_exp = '0;
    fired    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    dir_a = '{21'h000001, 21'h000009, 21'h100001, 21'h100003, 21'h100001, 21'h000003,
              21'h100000, 21'h0FFFFF, 21'h1FFFFF, 21'h103FFF, 21'h100000, 21'h000000};
    dir_b = '{21'h000002, 21'h000002, 21'h000002, 21'h000002, 21'h100003, 21'h100003,
              21'h100000, 21'h000001, 21'h100002, 21'h003FFF, 21'h100005, 21'h100000};

    rst_n = 1'b0;
    #2;
    check_eq("reset_sum", 32'(sum), 32'd0);
    check_eq("reset_valid", 32'(out_valid), 32'd0);
    check_eq("reset_ovf", 32'(ovf), 32'd0);
    #20;
    rst_n = 1'b1;

    // Back-to-back directed stream.
    for (int i = 0; i < 12; i++) drive(dir_a[i], dir_b[i]);
    idle(3);

    // Random stream with occasional gaps; some operands near full scale.
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = {1'($urandom()), 20'($urandom())};
      y = {1'($urandom()), 20'($urandom())};
      if ($urandom_range(0, 3) == 0) x[W-2:0] = 20'hFFFFF - 20'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) y[W-2:0] = x[W-2:0];
      drive(x, y);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(2);

    // Asynchronous reset mid-cycle with a result held on the output.
    drive(21'h000007, 21'h000008);
    idle(1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_sum", 32'(sum), 32'd0);
    check_eq("async_rst_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst_ovf", 32'(ovf), 32'd0);
    last_exp = '0;
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // First transaction after release must come out normally.
    drive(21'h100004, 21'h000001);
    drive(21'h0FFFFF, 21'h000001);
    idle(3);

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end

endmodule
